mem_port_credit_arbiter: RTL and testbench

- Round-robin arbiter with credit control that shares the DDR2 memory-controller address/write path between NREQ request ports (imem/dmem interleaved, port 2i = imem i, port 2i+1 = dmem i).
- Issues a one-hot grant mask and requester ID each enabled cycle.
- Limits each port's outstanding reads with a credit counter, returned on read completion.
- An aging counter prevents starvation of credit-limited or low-priority ports.

---
 rtl/mem_port_credit_arbiter_pkg.sv | 20 ++
 rtl/mem_port_credit_arbiter_if.sv | 31 +++
 rtl/mem_rr_pick.sv | 33 +++
 rtl/mem_port_credit_arbiter.sv | 129 ++++++++++++
 tb/tb_mem_port_credit_arbiter.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_port_credit_arbiter_pkg.sv
// Shared constants and types for the memory-port credit arbiter.
// Default port count follows the controller's imem/dmem pairing.
package mem_port_credit_arbiter_pkg;

  localparam int unsigned NMEMCTRLPORT     = 2;
  localparam int unsigned MEMARB_MAXOUT    = 4;
  localparam int unsigned MEMARB_AGE_LIMIT = 15;

  // Index width that never collapses to zero bits.
  function automatic int unsigned log2x(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  typedef struct packed {
    logic clk;
  } iu_clk_type;

  typedef bit [log2x(2*NMEMCTRLPORT)-1:0] mem_rid_type;

endpackage

// File: rtl/mem_port_credit_arbiter_if.sv
// Request/grant/return bundle between the memory ports and the credit arbiter.
// The arbiter takes the slave view of this bundle.
interface mem_port_credit_arbiter_if
  import mem_port_credit_arbiter_pkg::*;
#(
  parameter int unsigned NREQ = 2*NMEMCTRLPORT
) ();

  localparam int unsigned RIDW = log2x(NREQ);

  logic            en;
  logic [NREQ-1:0] port_valid;
  logic [NREQ-1:0] port_we;
  logic            ret_valid;
  logic [RIDW-1:0] ret_rid;
  logic [NREQ-1:0] port_mask;
  logic [RIDW-1:0] rid;
  logic            grant_valid;
  logic            credit_err;

  modport master (
    output en, port_valid, port_we, ret_valid, ret_rid,
    input  port_mask, rid, grant_valid, credit_err
  );

  modport slave (
    input  en, port_valid, port_we, ret_valid, ret_rid,
    output port_mask, rid, grant_valid, credit_err
  );

endinterface

// File: rtl/mem_rr_pick.sv
// Rotating-priority picker: first set request at or after ptr, wrapping.
// N must be a power of two so the index addition wraps by truncation.
module mem_rr_pick
  import mem_port_credit_arbiter_pkg::*;
#(
  parameter int unsigned N = 4,
  localparam int unsigned IW = log2x(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  logic [IW-1:0] cand;

  always_comb begin
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    cand = ptr;
    for (int k = 0; k < N; k++) begin
      cand = ptr + IW'(k);
      if (!any && req[cand]) begin
        any = 1'b1;
        idx = cand;
      end
    end
    if (any) gnt[idx] = 1'b1;
  end

endmodule

// File: rtl/mem_port_credit_arbiter.sv
// Round-robin credit arbiter sharing the memory-controller address/write path.
// Reads consume per-port credits; aged ports win ahead of the rotation.
module mem_port_credit_arbiter
  import mem_port_credit_arbiter_pkg::*;
#(
  parameter int unsigned NREQ      = 2*NMEMCTRLPORT,
  parameter int unsigned MAXOUT    = MEMARB_MAXOUT,
  parameter int unsigned AGE_LIMIT = MEMARB_AGE_LIMIT
) (
  input iu_clk_type              gclk,
  input logic                    rstn,
  mem_port_credit_arbiter_if.slave bus
);

  localparam int unsigned IW = log2x(NREQ);
  localparam int unsigned CW = $clog2(MAXOUT + 1);
  localparam int unsigned AW = $clog2(AGE_LIMIT + 1);

  logic [CW-1:0]   credit_q [NREQ];
  logic [CW-1:0]   credit_d [NREQ];
  logic [AW-1:0]   age_q    [NREQ];
  logic [AW-1:0]   age_d    [NREQ];
  logic [IW-1:0]   ptr_q;
  logic [NREQ-1:0] port_mask_q;
  logic [IW-1:0]   rid_q;
  logic            grant_valid_q;
  logic            credit_err_q;
  logic            credit_err_d;

  logic [NREQ-1:0] eligible;
  logic [NREQ-1:0] urgent;
  logic [NREQ-1:0] gnt_urg;
  logic [NREQ-1:0] gnt_rr;
  logic [IW-1:0]   idx_urg;
  logic [IW-1:0]   idx_rr;
  logic            any_urg;
  logic            any_rr;
  logic            do_grant;
  logic [NREQ-1:0] gmask;
  logic [IW-1:0]   gsel;

  always_comb begin
    eligible = '0;
    urgent   = '0;
    for (int i = 0; i < NREQ; i++) begin
      eligible[i] = bus.port_valid[i] & (bus.port_we[i] | (credit_q[i] != '0));
      urgent[i]   = eligible[i] & (age_q[i] >= AW'(AGE_LIMIT));
    end
  end

  mem_rr_pick #(
    .N (NREQ)
  ) u_pick_urg (
    .req (urgent),
    .ptr ({IW{1'b0}}),
    .gnt (gnt_urg),
    .idx (idx_urg),
    .any (any_urg)
  );

  mem_rr_pick #(
    .N (NREQ)
  ) u_pick_rr (
    .req (eligible),
    .ptr (ptr_q),
    .gnt (gnt_rr),
    .idx (idx_rr),
    .any (any_rr)
  );

  assign do_grant = bus.en & any_rr;
  assign gmask    = any_urg ? gnt_urg : gnt_rr;
  assign gsel     = any_urg ? idx_urg : idx_rr;

  always_comb begin
    credit_err_d = credit_err_q;
    for (int i = 0; i < NREQ; i++) begin
      logic dec;
      logic inc;
      dec = do_grant & gmask[i] & ~bus.port_we[i];
      inc = bus.ret_valid & (bus.ret_rid == IW'(i));
      credit_d[i] = credit_q[i];
      // A grant and a return on the same port in one cycle cancel out.
      if (inc && !dec) begin
        if (credit_q[i] == CW'(MAXOUT)) credit_err_d = 1'b1;
        else                            credit_d[i]  = credit_q[i] + 1'b1;
      end else if (dec && !inc) begin
        credit_d[i] = credit_q[i] - 1'b1;
      end

      age_d[i] = age_q[i];
      if (bus.en) begin
        if (do_grant && gmask[i])     age_d[i] = '0;
        else if (!bus.port_valid[i])  age_d[i] = '0;
        else if (age_q[i] < AW'(AGE_LIMIT)) age_d[i] = age_q[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge gclk.clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NREQ; i++) begin
        credit_q[i] <= CW'(MAXOUT);
        age_q[i]    <= '0;
      end
      ptr_q         <= '0;
      port_mask_q   <= '0;
      rid_q         <= '0;
      grant_valid_q <= 1'b0;
      credit_err_q  <= 1'b0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        credit_q[i] <= credit_d[i];
        age_q[i]    <= age_d[i];
      end
      if (do_grant) ptr_q <= gsel + 1'b1;
      port_mask_q   <= do_grant ? gmask : '0;
      rid_q         <= do_grant ? gsel : '0;
      grant_valid_q <= do_grant;
      credit_err_q  <= credit_err_d;
    end
  end

  assign bus.port_mask   = port_mask_q;
  assign bus.rid         = rid_q;
  assign bus.grant_valid = grant_valid_q;
  assign bus.credit_err  = credit_err_q;

endmodule

// File: tb/tb_mem_port_credit_arbiter.sv
// Directed bench for mem_port_credit_arbiter: NREQ=4, MAXOUT=4, AGE_LIMIT=3.
module tb_mem_port_credit_arbiter;
  import mem_port_credit_arbiter_pkg::*;

  int n_cmp  = 0;
  int n_fail = 0;

  logic       clk = 1'b0;
  logic       rstn;
  iu_clk_type gclk;

  assign gclk.clk = clk;
  always #5 clk = ~clk;

  mem_port_credit_arbiter_if #(.NREQ(4)) bus ();

  mem_port_credit_arbiter #(
    .NREQ      (4),
    .MAXOUT    (4),
    .AGE_LIMIT (3)
  ) dut (
    .gclk (gclk),
    .rstn (rstn),
    .bus  (bus)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rstn           = 1'b0;
    bus.en         = 1'b1;
    bus.port_valid = '0;
    bus.port_we    = '0;
    bus.ret_valid  = 1'b0;
    bus.ret_rid    = '0;
    step();
    step();
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    int exp_seq [5] = '{0, 1, 2, 3, 0};
    rstn           = 1'b0;
    bus.en         = 1'b1;
    bus.port_valid = 4'hF;
    bus.port_we    = 4'h0;
    bus.ret_valid  = 1'b0;
    bus.ret_rid    = '0;
    #2;
    n_cmp++;
    if (bus.port_mask !== 4'h0 || bus.rid !== 2'd0 || bus.grant_valid !== 1'b0 ||
        bus.credit_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: mask=%b rid=%0d gv=%b err=%b want 0000/0/0/0",
               bus.port_mask, bus.rid, bus.grant_valid, bus.credit_err);
    end
    step();
    rstn = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      n_cmp++;
      if (bus.port_mask !== 4'(1 << exp_seq[k]) || bus.rid !== 2'(exp_seq[k]) ||
          bus.grant_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL rr_order[%0d]: mask=%b rid=%0d gv=%b want port %0d",
                 k, bus.port_mask, bus.rid, bus.grant_valid, exp_seq[k]);
      end
    end
    // Reset lands between edges while a grant is showing.
    rstn = 1'b0;
    #2;
    n_cmp++;
    if (bus.port_mask !== 4'h0 || bus.rid !== 2'd0 || bus.grant_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: mask=%b rid=%0d gv=%b want 0000/0/0",
               bus.port_mask, bus.rid, bus.grant_valid);
    end
    rstn = 1'b1;
    step();
    n_cmp++;
    if (bus.port_mask !== 4'b0001 || bus.rid !== 2'd0) begin
      n_fail++;
      $display("FAIL ptr_after_reset: mask=%b rid=%0d want 0001/0", bus.port_mask, bus.rid);
    end
  endtask

  task automatic test_credit_exhaust();
    apply_reset();
    bus.port_valid = 4'b0010;
    bus.port_we    = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      step();
      n_cmp++;
      if (bus.port_mask !== 4'b0010 || bus.rid !== 2'd1) begin
        n_fail++;
        $display("FAIL credit_grant[%0d]: mask=%b rid=%0d want 0010/1",
                 k, bus.port_mask, bus.rid);
      end
    end
    for (int k = 0; k < 2; k++) begin
      step();
      n_cmp++;
      if (bus.port_mask !== 4'b0000 || bus.grant_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL credit_empty[%0d]: mask=%b gv=%b want 0000/0",
                 k, bus.port_mask, bus.grant_valid);
      end
    end
    bus.ret_valid = 1'b1;
    bus.ret_rid   = 2'd1;
    step();
    bus.ret_valid = 1'b0;
    n_cmp++;
    if (bus.port_mask !== 4'b0000) begin
      n_fail++;
      $display("FAIL return_lat1: mask=%b want 0000", bus.port_mask);
    end
    step();
    n_cmp++;
    if (bus.port_mask !== 4'b0010 || bus.grant_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL return_lat2: mask=%b gv=%b want 0010/1", bus.port_mask, bus.grant_valid);
    end
    step();
    n_cmp++;
    if (bus.port_mask !== 4'b0000 || bus.credit_err !== 1'b0) begin
      n_fail++;
      $display("FAIL return_once: mask=%b err=%b want 0000/0", bus.port_mask, bus.credit_err);
    end
  endtask

  task automatic test_write_bypass();
    apply_reset();
    bus.port_valid = 4'b1000;
    bus.port_we    = 4'b0000;
    for (int k = 0; k < 4; k++) step();
    step();
    n_cmp++;
    if (bus.port_mask !== 4'b0000) begin
      n_fail++;
      $display("FAIL wr_drain: mask=%b want 0000", bus.port_mask);
    end
    bus.port_we = 4'b1000;
    for (int k = 0; k < 2; k++) begin
      step();
      n_cmp++;
      if (bus.port_mask !== 4'b1000 || bus.rid !== 2'd3) begin
        n_fail++;
        $display("FAIL wr_grant[%0d]: mask=%b rid=%0d want 1000/3", k, bus.port_mask, bus.rid);
      end
    end
    bus.port_we = 4'b0000;
    step();
    n_cmp++;
    if (bus.port_mask !== 4'b0000) begin
      n_fail++;
      $display("FAIL wr_no_credit: mask=%b want 0000", bus.port_mask);
    end
  endtask

  task automatic test_starvation();
    int exp_seq [10] = '{3, 0, 1, 3, 0, 1, 3, 0, 1, 3};
    apply_reset();
    bus.port_valid = 4'b0100;
    bus.port_we    = 4'b0000;
    for (int k = 0; k < 4; k++) step();
    bus.port_valid = 4'b1111;
    bus.port_we    = 4'b1011;
    for (int k = 0; k < 10; k++) begin
      step();
      n_cmp++;
      if (bus.port_mask !== 4'(1 << exp_seq[k]) || bus.rid !== 2'(exp_seq[k])) begin
        n_fail++;
        $display("FAIL starve_rr[%0d]: mask=%b rid=%0d want port %0d",
                 k, bus.port_mask, bus.rid, exp_seq[k]);
      end
    end
    bus.ret_valid = 1'b1;
    bus.ret_rid   = 2'd2;
    step();
    bus.ret_valid = 1'b0;
    n_cmp++;
    if (bus.rid !== 2'd0) begin
      n_fail++;
      $display("FAIL starve_ret_cycle: rid=%0d want 0", bus.rid);
    end
    step();
    n_cmp++;
    if (bus.port_mask !== 4'b0100 || bus.rid !== 2'd2) begin
      n_fail++;
      $display("FAIL starve_urgent: mask=%b rid=%0d want 0100/2", bus.port_mask, bus.rid);
    end
  endtask

  task automatic test_en_gating();
    apply_reset();
    bus.port_valid = 4'hF;
    bus.port_we    = 4'hF;
    step();
    step();
    n_cmp++;
    if (bus.rid !== 2'd1) begin
      n_fail++;
      $display("FAIL en_pre: rid=%0d want 1", bus.rid);
    end
    bus.en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      n_cmp++;
      if (bus.port_mask !== 4'b0000 || bus.grant_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL en_off[%0d]: mask=%b gv=%b want 0000/0", k, bus.port_mask, bus.grant_valid);
      end
    end
    bus.en = 1'b1;
    step();
    n_cmp++;
    if (bus.port_mask !== 4'b0100 || bus.rid !== 2'd2) begin
      n_fail++;
      $display("FAIL en_resume: mask=%b rid=%0d want 0100/2", bus.port_mask, bus.rid);
    end
    step();
    n_cmp++;
    if (bus.port_mask !== 4'b1000) begin
      n_fail++;
      $display("FAIL en_resume2: mask=%b want 1000", bus.port_mask);
    end
  endtask

  task automatic test_overflow();
    apply_reset();
    bus.ret_valid = 1'b1;
    bus.ret_rid   = 2'd0;
    step();
    bus.ret_valid = 1'b0;
    n_cmp++;
    if (bus.credit_err !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_set: err=%b want 1", bus.credit_err);
    end
    for (int k = 0; k < 3; k++) step();
    n_cmp++;
    if (bus.credit_err !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_sticky: err=%b want 1", bus.credit_err);
    end
    bus.port_valid = 4'b0001;
    bus.port_we    = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      step();
      n_cmp++;
      if (bus.port_mask !== 4'b0001) begin
        n_fail++;
        $display("FAIL ovf_credit[%0d]: mask=%b want 0001", k, bus.port_mask);
      end
    end
    step();
    n_cmp++;
    if (bus.port_mask !== 4'b0000 || bus.credit_err !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_saturate: mask=%b err=%b want 0000/1", bus.port_mask, bus.credit_err);
    end
    rstn = 1'b0;
    #1;
    n_cmp++;
    if (bus.credit_err !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_reset_clear: err=%b want 0", bus.credit_err);
    end
    rstn = 1'b1;
  endtask

  initial begin
    test_reset();
    test_credit_exhaust();
    test_write_bypass();
    test_starvation();
    test_en_gating();
    test_overflow();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
